// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite types and helpers for the register slave.
// Response codes and byte-lane merge.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  // Widest supported word is 64 bits; callers zero-extend and truncate.
  function automatic logic [63:0] apply_strb(
    input logic [63:0] old_word,
    input logic [63:0] new_word,
    input logic [7:0]  strb
  );
    logic [63:0] res;
    res = old_word;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_wr_ctrl.sv
// AXI-Lite write control: AW/W hold flags, commit and B channel.
// Produces a one-cycle commit request for the register array.
module axi_lite_wr_ctrl
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                aw_valid,
  output logic                aw_ready,
  input  logic [ADDR_W-1:0]   aw_addr,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                b_valid,
  input  logic                b_ready,
  output resp_t               b_resp,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb
);

  localparam int OFFS = $clog2(DATA_W / 8);

  logic                aw_hold;
  logic                w_hold;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W/8-1:0] strb_q;
  logic                aw_hs;
  logic                w_hs;
  logic                commit;
  logic                in_range;
  logic [ADDR_W-1:0]   cur_addr;

  assign aw_ready = !aw_hold && !b_valid;
  assign w_ready  = !w_hold && !b_valid;
  assign aw_hs    = aw_valid && aw_ready;
  assign w_hs     = w_valid && w_ready;
  assign commit   = (aw_hold || aw_hs) && (w_hold || w_hs);

  assign cur_addr = aw_hold ? addr_q : aw_addr;
  assign wr_idx   = cur_addr >> OFFS;
  assign wr_data  = w_hold ? data_q : w_data;
  assign wr_strb  = w_hold ? strb_q : w_strb;
  assign in_range = {1'b0, wr_idx} < (ADDR_W + 1)'(NUM_REGS);
  assign wr_en    = commit && in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      b_valid <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      if (aw_hs) addr_q <= aw_addr;
      if (w_hs) begin
        data_q <= w_data;
        strb_q <= w_strb;
      end
      if (commit) begin
        aw_hold <= 1'b0;
        w_hold  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) aw_hold <= 1'b1;
        if (w_hs) w_hold <= 1'b1;
        if (b_valid && b_ready) b_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register bank endpoint with per-register write pulses.
// Read path and register array live here; writes go through wr_ctrl.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int              ADDR_W    = 12,
  parameter int              DATA_W    = 32,
  parameter int              NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aw_valid,
  output logic                       aw_ready,
  input  logic [ADDR_W-1:0]          aw_addr,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [DATA_W-1:0]          w_data,
  input  logic [DATA_W/8-1:0]        w_strb,
  output logic                       b_valid,
  input  logic                       b_ready,
  output logic [1:0]                 b_resp,
  input  logic                       ar_valid,
  output logic                       ar_ready,
  input  logic [ADDR_W-1:0]          ar_addr,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [DATA_W-1:0]          r_data,
  output logic [1:0]                 r_resp,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]        wr_pulse
);

  localparam int OFFS = $clog2(DATA_W / 8);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  resp_t               b_resp_t;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_idx;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W/8-1:0] wr_strb;
  logic [ADDR_W-1:0]   ar_idx;
  logic                ar_ok;
  logic                ar_hs;
  logic [DATA_W-1:0]   rd_word;

  axi_lite_wr_ctrl #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_wr_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .aw_addr  (aw_addr),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_resp   (b_resp_t),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb)
  );

  assign b_resp = b_resp_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && wr_idx == ADDR_W'(i)) begin
          regs[i] <= DATA_W'(apply_strb(64'(regs[i]), 64'(wr_data),
                                         8'(wr_strb)));
          if (wr_strb != '0) wr_pulse[i] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign reg_q[g*DATA_W +: DATA_W] = regs[g];
  end

  assign ar_ready = !r_valid;
  assign ar_hs    = ar_valid && ar_ready;
  assign ar_idx   = ar_addr >> OFFS;
  assign ar_ok    = {1'b0, ar_idx} < (ADDR_W + 1)'(NUM_REGS);

  // Sampled before this edge's write lands, so same-edge reads see old data.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == ADDR_W'(i)) rd_word = regs[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= ar_ok ? rd_word : '0;
      r_resp  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a per-cycle reference model.
// Model works on byte arrays and pending-transaction flags.
module tb_axi_lite_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         aw_valid = 1'b0;
  logic         aw_ready;
  logic [11:0]  aw_addr = '0;
  logic         w_valid = 1'b0;
  logic         w_ready;
  logic [31:0]  w_data = '0;
  logic [3:0]   w_strb = '0;
  logic         b_valid;
  logic         b_ready = 1'b1;
  logic [1:0]   b_resp;
  logic         ar_valid = 1'b0;
  logic         ar_ready;
  logic [11:0]  ar_addr = '0;
  logic         r_valid;
  logic         r_ready = 1'b1;
  logic [31:0]  r_data;
  logic [1:0]   r_resp;
  logic [511:0] reg_q;
  logic [15:0]  wr_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_reg_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .aw_addr  (aw_addr),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .w_strb   (w_strb),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_resp   (b_resp),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .ar_addr  (ar_addr),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .r_resp   (r_resp),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model state
  logic [7:0]  mb [16][4];
  bit          awp, wp, bp, rp;
  logic [11:0] m_aa;
  logic [31:0] m_wd;
  logic [3:0]  m_ws;
  logic [1:0]  e_b, e_rresp;
  logic [31:0] e_r;
  logic [15:0] e_pulse;

  task automatic model_reset();
    for (int i = 0; i < 16; i++)
      for (int b = 0; b < 4; b++) mb[i][b] = 8'h00;
    awp = 0; wp = 0; bp = 0; rp = 0;
    e_b = 2'b00; e_rresp = 2'b00; e_r = '0; e_pulse = '0;
  endtask

  function automatic logic [31:0] mword(input int i);
    return {mb[i][3], mb[i][2], mb[i][1], mb[i][0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_aw_ready", aw_ready, 1);
      check("rst_w_ready", w_ready, 1);
      check("rst_ar_ready", ar_ready, 1);
      check("rst_b_valid", b_valid, 0);
      check("rst_r_valid", r_valid, 0);
      check("rst_r_data", r_data, 0);
      check("rst_wr_pulse", wr_pulse, 0);
      check("rst_reg_q_lo", reg_q[63:0], 0);
      model_reset();
    end else begin
      int idx;
      bit awhs, whs, arhs;
      logic [15:0] np;
      check("aw_ready", aw_ready, !awp && !bp);
      check("w_ready", w_ready, !wp && !bp);
      check("ar_ready", ar_ready, !rp);
      check("b_valid", b_valid, bp);
      if (bp) check("b_resp", b_resp, e_b);
      check("r_valid", r_valid, rp);
      if (rp) begin
        check("r_data", r_data, e_r);
        check("r_resp", r_resp, e_rresp);
      end
      check("wr_pulse", wr_pulse, e_pulse);
      for (int i = 0; i < 16; i++)
        check($sformatf("reg%0d", i), reg_q[i*32 +: 32], mword(i));
      // Predict the effect of the coming rising edge
      awhs = aw_valid && !awp && !bp;
      whs  = w_valid && !wp && !bp;
      arhs = ar_valid && !rp;
      np = '0;
      if (rp && r_ready) rp = 0;
      if (arhs) begin
        idx = int'(ar_addr) / 4;
        rp = 1;
        e_r = (idx < 16) ? mword(idx) : 32'h0;
        e_rresp = (idx < 16) ? 2'b00 : 2'b10;
      end
      if (bp && b_ready) bp = 0;
      if (awhs) begin awp = 1; m_aa = aw_addr; end
      if (whs) begin wp = 1; m_wd = w_data; m_ws = w_strb; end
      if (awp && wp) begin
        idx = int'(m_aa) / 4;
        if (idx < 16) begin
          for (int b = 0; b < 4; b++)
            if (m_ws[b]) mb[idx][b] = m_wd[b*8 +: 8];
          e_b = 2'b00;
          if (m_ws != 0) np[idx] = 1'b1;
        end else begin
          e_b = 2'b10;
        end
        bp = 1; awp = 0; wp = 0;
      end
      e_pulse = np;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [11:0] a);
    bit done = 0;
    aw_addr = a; aw_valid = 1;
    for (int k = 0; k < 20; k++)
      if (!done) begin @(negedge clk); if (aw_ready) done = 1; end
    check("aw_timeout", done, 1);
    @(posedge clk); #1;
    aw_valid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit done = 0;
    w_data = d; w_strb = s; w_valid = 1;
    for (int k = 0; k < 20; k++)
      if (!done) begin @(negedge clk); if (w_ready) done = 1; end
    check("w_timeout", done, 1);
    @(posedge clk); #1;
    w_valid = 0;
  endtask

  task automatic read(input logic [11:0] a, output logic [31:0] d,
                      output logic [1:0] rs);
    bit done = 0;
    ar_addr = a; ar_valid = 1;
    for (int k = 0; k < 20; k++)
      if (!done) begin @(negedge clk); if (ar_ready) done = 1; end
    check("ar_timeout", done, 1);
    @(posedge clk); #1;
    ar_valid = 0;
    done = 0; d = '0; rs = '0;
    for (int k = 0; k < 20; k++)
      if (!done) begin
        @(negedge clk);
        if (r_valid) begin done = 1; d = r_data; rs = r_resp; end
      end
    check("r_timeout", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    fork
      send_aw(a);
      send_w(d, s);
    join
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  rs;
    model_reset();
    idle(3);
    rst_n = 1;
    idle(2);

    // 1: AW and W together
    write(12'h004, 32'hA5A5A5A5, 4'hF);
    check("t1_b_valid", b_valid, 1);
    check("t1_b_resp", b_resp, 2'b00);
    check("t1_pulse", wr_pulse, 16'h0002);
    idle(1);
    check("t1_pulse_clear", wr_pulse, 16'h0000);
    check("t1_reg1", reg_q[63:32], 32'hA5A5A5A5);
    idle(2);

    // 2: W first, AW three cycles later
    send_w(32'h11223344, 4'b0101);
    check("t2_no_b", b_valid, 0);
    idle(3);
    send_aw(12'h008);
    check("t2_b_valid", b_valid, 1);
    check("t2_reg2", reg_q[95:64], 32'h00220044);
    idle(3);

    // 3: out-of-range accesses
    read(12'h040, d, rs);
    check("t3_rd_resp", rs, 2'b10);
    check("t3_rd_data", d, 0);
    write(12'h040, 32'hFFFFFFFF, 4'hF);
    check("t3_wr_resp", b_resp, 2'b10);
    check("t3_no_pulse", wr_pulse, 0);
    idle(3);

    // 4: stalled responses block new requests
    b_ready = 0; r_ready = 0;
    write(12'h010, 32'hDEADBEEF, 4'hF);
    read(12'h004, d, rs);
    repeat (5) begin
      @(negedge clk);
      check("t4_aw_ready", aw_ready, 0);
      check("t4_w_ready", w_ready, 0);
      check("t4_ar_ready", ar_ready, 0);
      check("t4_r_data", r_data, 32'hA5A5A5A5);
    end
    @(posedge clk); #1;
    b_ready = 1; r_ready = 1;
    idle(3);

    // 5: read and write to reg3 on the same edge
    write(12'h00C, 32'h1, 4'hF);
    idle(3);
    send_w(32'h2, 4'hF);
    fork
      send_aw(12'h00C);
      read(12'h00C, d, rs);
    join
    check("t5_old", d, 32'h1);
    idle(2);
    read(12'h00C, d, rs);
    check("t5_new", d, 32'h2);
    idle(2);

    // 6: reset with a held AW and a pending R
    r_ready = 0;
    read(12'h008, d, rs);
    send_aw(12'h014);
    #1 rst_n = 0;
    #1;
    check("t6_r_valid", r_valid, 0);
    check("t6_aw_ready", aw_ready, 1);
    check("t6_reg2", reg_q[95:64], 0);
    idle(2);
    rst_n = 1; r_ready = 1;
    idle(1);
    send_w(32'h5, 4'hF);
    idle(4);
    check("t6_no_b", b_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
